// File: rtl/bram_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and the cpu_bram port.
// slave: arbiter view. master: requester/memory-environment view.
`timescale 1ns/1ps
interface bram_arbiter_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned BE_W = DATA_W / 8;

   logic              p0_req,    p1_req;
   logic              p0_we,     p1_we;
   logic              p0_lock,   p1_lock;
   logic [ADDR_W-1:0] p0_addr,   p1_addr;
   logic [BE_W-1:0]   p0_be,     p1_be;
   logic [DATA_W-1:0] p0_wdata,  p1_wdata;
   logic              p0_gnt,    p1_gnt;
   logic              p0_rvalid, p1_rvalid;
   logic [DATA_W-1:0] p0_rdata,  p1_rdata;

   logic [ADDR_W-1:0] mem_address;
   logic [BE_W-1:0]   mem_byteena;
   logic [DATA_W-1:0] mem_data;
   logic              mem_rden;
   logic              mem_wren;
   logic [DATA_W-1:0] mem_q;

   modport slave (
      input  p0_req, p0_we, p0_lock, p0_addr, p0_be, p0_wdata,
      input  p1_req, p1_we, p1_lock, p1_addr, p1_be, p1_wdata,
      output p0_gnt, p0_rvalid, p0_rdata,
      output p1_gnt, p1_rvalid, p1_rdata,
      output mem_address, mem_byteena, mem_data, mem_rden, mem_wren,
      input  mem_q
   );

   modport master (
      output p0_req, p0_we, p0_lock, p0_addr, p0_be, p0_wdata,
      output p1_req, p1_we, p1_lock, p1_addr, p1_be, p1_wdata,
      input  p0_gnt, p0_rvalid, p0_rdata,
      input  p1_gnt, p1_rvalid, p1_rdata,
      input  mem_address, mem_byteena, mem_data, mem_rden, mem_wren,
      output mem_q
   );
endinterface

// File: rtl/bram_arbiter.sv
// Two-port arbiter in front of a single-port cpu_bram.
// Grants are combinational (one access per cycle), reads return one cycle later.
// Ties in OPEN are round-robin; define BRAM_ARB_FIXED_PRIO_EN to make port 0
// always win ties (the last-grant pointer is then not built).
// A locked grant keeps the owning port exclusive until it issues an unlocked access.
`timescale 1ns/1ps
module bram_arbiter #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 32
) (
   input logic           clock,
   input logic           sclr,
   bram_arbiter_if.slave bus
);
   localparam int unsigned BE_W = DATA_W / 8;

   typedef enum logic [1:0] {
      ST_OPEN = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_gnt0;
   logic              w_gnt1;
   logic              w_win0;
   logic [ADDR_W-1:0] r_addr;
   logic [BE_W-1:0]   r_be;
   logic [DATA_W-1:0] r_data;
   logic              r_rv0;
   logic              r_rv1;

`ifndef BRAM_ARB_FIXED_PRIO_EN
   logic              r_last;   // 1: port 1 was granted most recently

   // Last-grant pointer for round-robin tie breaking
   always_ff @(posedge clock) begin
      if (sclr)        r_last <= 1'b1;
      else if (w_gnt0) r_last <= 1'b0;
      else if (w_gnt1) r_last <= 1'b1;
   end
`endif

   // Tie winner in OPEN: port 0 wins if it was not the last one served
   always_comb begin
`ifdef BRAM_ARB_FIXED_PRIO_EN
      w_win0 = 1'b1;
`else
      w_win0 = r_last;
`endif
   end

   // Grant decision and next state
   always_comb begin
      w_gnt0      = 1'b0;
      w_gnt1      = 1'b0;
      w_state_nxt = r_state;
      if (!sclr) begin
         case (r_state)
            ST_OPEN: begin
               if (bus.p0_req && bus.p1_req) begin
                  w_gnt0 = w_win0;
                  w_gnt1 = !w_win0;
               end else begin
                  w_gnt0 = bus.p0_req;
                  w_gnt1 = bus.p1_req;
               end
            end
            ST_OWN0: w_gnt0 = bus.p0_req;
            ST_OWN1: w_gnt1 = bus.p1_req;
            default: ;
         endcase
         if (w_gnt0)      w_state_nxt = bus.p0_lock ? ST_OWN0 : ST_OPEN;
         else if (w_gnt1) w_state_nxt = bus.p1_lock ? ST_OWN1 : ST_OPEN;
      end
   end

   // State register
   always_ff @(posedge clock) begin
      if (sclr) r_state <= ST_OPEN;
      else      r_state <= w_state_nxt;
   end

   // Last granted address/byte-enable/data, held on idle cycles
   always_ff @(posedge clock) begin
      if (sclr) begin
         r_addr <= '0;
         r_be   <= '0;
         r_data <= '0;
      end else if (w_gnt0) begin
         r_addr <= bus.p0_addr;
         r_be   <= bus.p0_be;
         r_data <= bus.p0_wdata;
      end else if (w_gnt1) begin
         r_addr <= bus.p1_addr;
         r_be   <= bus.p1_be;
         r_data <= bus.p1_wdata;
      end
   end

   // Read-valid pipeline, one cycle behind the read grant
   always_ff @(posedge clock) begin
      if (sclr) begin
         r_rv0 <= 1'b0;
         r_rv1 <= 1'b0;
      end else begin
         r_rv0 <= w_gnt0 && !bus.p0_we;
         r_rv1 <= w_gnt1 && !bus.p1_we;
      end
   end

   // Memory-side mux: granted port drives the bus, otherwise hold last values
   always_comb begin
      bus.mem_address = r_addr;
      bus.mem_byteena = r_be;
      bus.mem_data    = r_data;
      bus.mem_rden    = 1'b0;
      bus.mem_wren    = 1'b0;
      if (sclr) begin
         bus.mem_address = '0;
         bus.mem_byteena = '0;
         bus.mem_data    = '0;
      end else if (w_gnt0) begin
         bus.mem_address = bus.p0_addr;
         bus.mem_byteena = bus.p0_be;
         bus.mem_data    = bus.p0_wdata;
         bus.mem_rden    = !bus.p0_we;
         bus.mem_wren    = bus.p0_we;
      end else if (w_gnt1) begin
         bus.mem_address = bus.p1_addr;
         bus.mem_byteena = bus.p1_be;
         bus.mem_data    = bus.p1_wdata;
         bus.mem_rden    = !bus.p1_we;
         bus.mem_wren    = bus.p1_we;
      end
   end

   // Requester-side outputs; a read in flight when sclr rises is dropped
   always_comb begin
      bus.p0_gnt    = w_gnt0;
      bus.p1_gnt    = w_gnt1;
      bus.p0_rvalid = r_rv0 && !sclr;
      bus.p1_rvalid = r_rv1 && !sclr;
      bus.p0_rdata  = bus.mem_q;
      bus.p1_rdata  = bus.mem_q;
   end
endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter: directed scenarios followed by random
// traffic, compared against a transaction-level arbiter/memory reference.
`timescale 1ns/1ps
module tb_bram_arbiter;
   logic clock = 1'b0;
   logic sclr  = 1'b1;
   always #5 clock = ~clock;

   bram_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus ();
   bram_arbiter #(.ADDR_W(16), .DATA_W(32)) dut (
      .clock (clock),
      .sclr  (sclr),
      .bus   (bus.slave)
   );

   // cpu_bram stand-in: 16 words, byte-enabled writes, registered reads
   logic [31:0] bram [16];
   always @(posedge clock) begin
      if (bus.mem_wren)
         for (int b = 0; b < 4; b++)
            if (bus.mem_byteena[b]) bram[bus.mem_address[3:0]][8*b +: 8] <= bus.mem_data[8*b +: 8];
      if (bus.mem_rden) bus.mem_q <= bram[bus.mem_address[3:0]];
   end

   // Reference model state
   int          m_owner;      // -1: nobody owns the memory, else owning port
   int          m_last;       // port granted most recently
   logic [31:0] ref_mem [16];
   logic [15:0] m_haddr;
   logic [3:0]  m_hbe;
   logic [31:0] m_hdata;
   bit          m_rv0, m_rv1;
   logic [31:0] m_rd0, m_rd1;

   int n_tests = 0;
   int n_fail  = 0;

   // Observations from the last cycle, used by scenario checks
   logic        obs_g0, obs_g1, obs_rv0, obs_rv1;
   logic [31:0] obs_rd0, obs_rd1;
   bit          g_e0, g_e1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Which port the rules say is granted given the current requests
   task automatic model_grant(output bit e0, output bit e1);
      e0 = 1'b0;
      e1 = 1'b0;
      if (sclr) return;
      if (m_owner == 0)      e0 = bus.p0_req;
      else if (m_owner == 1) e1 = bus.p1_req;
      else if (bus.p0_req && bus.p1_req) begin
`ifdef BRAM_ARB_FIXED_PRIO_EN
         e0 = 1'b1;
`else
         if (m_last == 1) e0 = 1'b1; else e1 = 1'b1;
`endif
      end else begin
         e0 = bus.p0_req;
         e1 = bus.p1_req;
      end
   endtask

   task automatic mem_write(input logic [15:0] a, input logic [3:0] be, input logic [31:0] d);
      for (int b = 0; b < 4; b++)
         if (be[b]) ref_mem[a[3:0]][8*b +: 8] = d[8*b +: 8];
   endtask

   // One clock: check everything at the negedge, advance the model at the posedge
   task automatic cycle();
      bit e0, e1;
      logic [15:0] ea;
      logic [3:0]  eb;
      logic [31:0] ed;
      logic        erd, ewr;
      @(negedge clock);
      model_grant(e0, e1);
      g_e0 = e0;
      g_e1 = e1;
      ea = m_haddr; eb = m_hbe; ed = m_hdata; erd = 1'b0; ewr = 1'b0;
      if (sclr) begin
         ea = '0; eb = '0; ed = '0;
      end else if (e0) begin
         ea = bus.p0_addr; eb = bus.p0_be; ed = bus.p0_wdata; erd = !bus.p0_we; ewr = bus.p0_we;
      end else if (e1) begin
         ea = bus.p1_addr; eb = bus.p1_be; ed = bus.p1_wdata; erd = !bus.p1_we; ewr = bus.p1_we;
      end
      chk("p0_gnt", bus.p0_gnt, e0);
      chk("p1_gnt", bus.p1_gnt, e1);
      chk("gnt_excl", bus.p0_gnt & bus.p1_gnt, 0);
      chk("rw_excl", bus.mem_rden & bus.mem_wren, 0);
      chk("mem_rden", bus.mem_rden, erd);
      chk("mem_wren", bus.mem_wren, ewr);
      chk("mem_address", bus.mem_address, ea);
      chk("mem_byteena", bus.mem_byteena, eb);
      chk("mem_data", bus.mem_data, ed);
      chk("p0_rvalid", bus.p0_rvalid, m_rv0 && !sclr);
      chk("p1_rvalid", bus.p1_rvalid, m_rv1 && !sclr);
      if (m_rv0 && !sclr) chk("p0_rdata", bus.p0_rdata, m_rd0);
      if (m_rv1 && !sclr) chk("p1_rdata", bus.p1_rdata, m_rd1);
      obs_g0 = bus.p0_gnt;  obs_g1 = bus.p1_gnt;
      obs_rv0 = bus.p0_rvalid; obs_rv1 = bus.p1_rvalid;
      obs_rd0 = bus.p0_rdata;  obs_rd1 = bus.p1_rdata;
      @(posedge clock);
      if (sclr) begin
         m_owner = -1; m_last = 1;
         m_haddr = '0; m_hbe = '0; m_hdata = '0;
         m_rv0 = 1'b0; m_rv1 = 1'b0;
      end else begin
         m_rv0 = e0 && !bus.p0_we;
         m_rv1 = e1 && !bus.p1_we;
         if (m_rv0) m_rd0 = ref_mem[bus.p0_addr[3:0]];
         if (m_rv1) m_rd1 = ref_mem[bus.p1_addr[3:0]];
         if (e0) begin
            if (bus.p0_we) mem_write(bus.p0_addr, bus.p0_be, bus.p0_wdata);
            m_haddr = bus.p0_addr; m_hbe = bus.p0_be; m_hdata = bus.p0_wdata;
            m_last = 0;
            m_owner = bus.p0_lock ? 0 : -1;
         end else if (e1) begin
            if (bus.p1_we) mem_write(bus.p1_addr, bus.p1_be, bus.p1_wdata);
            m_haddr = bus.p1_addr; m_hbe = bus.p1_be; m_hdata = bus.p1_wdata;
            m_last = 1;
            m_owner = bus.p1_lock ? 1 : -1;
         end
      end
      #1;
   endtask

   task automatic set_p0(input bit req, input bit we, input bit lock, input logic [15:0] a,
                         input logic [3:0] be, input logic [31:0] d);
      bus.p0_req = req; bus.p0_we = we; bus.p0_lock = lock;
      bus.p0_addr = a; bus.p0_be = be; bus.p0_wdata = d;
   endtask

   task automatic set_p1(input bit req, input bit we, input bit lock, input logic [15:0] a,
                         input logic [3:0] be, input logic [31:0] d);
      bus.p1_req = req; bus.p1_we = we; bus.p1_lock = lock;
      bus.p1_addr = a; bus.p1_be = be; bus.p1_wdata = d;
   endtask

   logic [3:0] seq0;
   logic [3:0] exp_seq0;

   initial begin
      for (int i = 0; i < 16; i++) begin
         bram[i]    = '0;
         ref_mem[i] = '0;
      end
      m_owner = -1; m_last = 1;
      m_haddr = '0; m_hbe = '0; m_hdata = '0;
      m_rv0 = 1'b0; m_rv1 = 1'b0; m_rd0 = '0; m_rd1 = '0;

      // Reset with both ports requesting: nothing may be granted
      sclr = 1'b1;
      set_p0(1, 1, 1, 16'h0001, 4'hF, 32'h1111_1111);
      set_p1(1, 0, 1, 16'h0002, 4'hF, 32'h2222_2222);
      cycle();
      cycle();
      chk("rst_gnt", {obs_g0, obs_g1}, 2'b00);
      sclr = 1'b0;
      set_p0(0, 0, 0, 0, 0, 0);
      set_p1(0, 0, 0, 0, 0, 0);
      cycle();

      // p0 write then read of addr 3
      set_p0(1, 1, 0, 16'h0003, 4'hF, 32'hA000_0003);
      cycle();
      set_p0(1, 0, 0, 16'h0003, 4'hF, 32'h0);
      cycle();
      set_p0(0, 0, 0, 0, 0, 0);
      cycle();
      chk("s_wr_rd_rvalid", obs_rv0, 1'b1);
      chk("s_wr_rd_rdata", obs_rd0, 32'hA000_0003);

      // Continuous tie for 4 cycles right after reset
      sclr = 1'b1;
      cycle();
      sclr = 1'b0;
      set_p0(1, 0, 0, 16'h0004, 4'hF, 0);
      set_p1(1, 0, 0, 16'h0005, 4'hF, 0);
      for (int i = 0; i < 4; i++) begin
         cycle();
         seq0[i] = obs_g0;
      end
`ifdef BRAM_ARB_FIXED_PRIO_EN
      exp_seq0 = 4'b1111;
`else
      exp_seq0 = 4'b0101;
`endif
      chk("s_tie_seq", seq0, exp_seq0);
      set_p0(0, 0, 0, 0, 0, 0);
      set_p1(0, 0, 0, 0, 0, 0);
      cycle();

      // p1 partial write over zero, then read back
      set_p1(1, 1, 0, 16'h000A, 4'b0011, 32'hDEAD_BEEF);
      cycle();
      set_p1(1, 0, 0, 16'h000A, 4'hF, 0);
      cycle();
      set_p1(0, 0, 0, 0, 0, 0);
      cycle();
      chk("s_be_rvalid", obs_rv1, 1'b1);
      chk("s_be_rdata", obs_rd1, 32'h0000_BEEF);

      // Lock: p1 locked out until p0 releases
      set_p0(1, 0, 1, 16'h0005, 4'hF, 0);
      cycle();
      set_p1(1, 0, 0, 16'h0006, 4'hF, 0);
      set_p0(1, 1, 1, 16'h0007, 4'hF, 32'h7777_0007);
      cycle();
      chk("s_lock_c2", {obs_g0, obs_g1}, 2'b10);
      set_p0(1, 0, 0, 16'h0007, 4'hF, 0);
      cycle();
      chk("s_lock_c3", {obs_g0, obs_g1}, 2'b10);
      set_p0(0, 0, 0, 0, 0, 0);
      cycle();
      chk("s_lock_c4", {obs_g0, obs_g1}, 2'b01);
      set_p1(0, 0, 0, 0, 0, 0);
      cycle();

      // Read in flight when sclr rises: rvalid dropped, pointer back to 1
      set_p0(1, 0, 0, 16'h000B, 4'hF, 0);
      cycle();
      set_p0(0, 0, 0, 0, 0, 0);
      sclr = 1'b1;
      cycle();
      chk("s_rst_rvalid", obs_rv0, 1'b0);
      sclr = 1'b0;
      set_p0(1, 0, 0, 16'h000C, 4'hF, 0);
      set_p1(1, 0, 0, 16'h000D, 4'hF, 0);
      cycle();
      chk("s_rst_tie", {obs_g0, obs_g1}, 2'b10);
      set_p0(0, 0, 0, 0, 0, 0);
      set_p1(0, 0, 0, 0, 0, 0);
      cycle();

      // Random traffic; requests stay stable until granted
      for (int n = 0; n < 600; n++) begin
         sclr = ($urandom_range(0, 39) == 0);
         if (!(bus.p0_req && !g_e0))
            set_p0($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                   16'($urandom_range(0, 15)), 4'($urandom), $urandom);
         if (!(bus.p1_req && !g_e1))
            set_p1($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                   16'($urandom_range(0, 15)), 4'($urandom), $urandom);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning data width; byte-enable width SHALL be DATA_W/8.
REQ-003 The block SHALL have ports clock  in  1  the only clock, all logic on its rising edge.
REQ-004 The block SHALL have ports sclr  in  1  reset, synchronous and active-high.
REQ-005 The block SHALL have ports p0_req, p1_req  in  1 each  access request, held until granted.
REQ-006 The block SHALL have ports p0_we, p1_we  in  1 each  1 = write, 0 = read.
REQ-007 The block SHALL have ports p0_lock, p1_lock  in  1 each  keep ownership after this access.
REQ-008 The block SHALL have ports p0_addr, p1_addr  in  ADDR_W each  word address.
REQ-009 The block SHALL have ports p0_be, p1_be  in  DATA_W/8 each  byte enables.
REQ-010 The block SHALL have ports p0_wdata, p1_wdata  in  DATA_W each  write data.
REQ-011 The block SHALL have ports p0_gnt, p1_gnt  out  1 each  access accepted this cycle (combinational).
REQ-012 The block SHALL have ports p0_rvalid, p1_rvalid  out  1 each  read data valid.
REQ-013 The block SHALL have ports p0_rdata, p1_rdata  out  DATA_W each  read data, both driven from mem_q.
REQ-014 The block SHALL have ports mem_address  out  ADDR_W, mem_byteena  out  DATA_W/8, mem_data  out  DATA_W, mem_rden  out  1, mem_wren  out  1, for the cpu_bram side.
REQ-015 The block SHALL have ports mem_q  in  DATA_W  cpu_bram read data, valid one cycle after mem_rden.

Function
REQ-016 The block SHALL grant at most one port per cycle; p0_gnt and p1_gnt SHALL never both be 1.
REQ-017 When a port is granted, its addr/be/wdata SHALL drive the mem_* buses in that cycle, with mem_wren = we and mem_rden = !we.
REQ-018 When no port is granted, mem_rden and mem_wren SHALL be 0 and mem_address/byteena/data SHALL hold their last granted values.
REQ-019 A granted read SHALL assert the matching pN_rvalid for exactly one cycle, one cycle after the grant, with pN_rdata = mem_q.
REQ-020 Writes SHALL produce no rvalid.
REQ-021 Sustained throughput SHALL be one access per cycle; a port may be granted on consecutive cycles.
REQ-022 The FSM SHALL have states OPEN, OWN0 and OWN1; the reset state SHALL be OPEN.
REQ-023 In OPEN, a sole requester SHALL be granted.
REQ-024 In OPEN with both requesting, the port not granted most recently SHALL win (round-robin); the last-grant pointer SHALL reset to 1, so port 0 wins the first tie.
REQ-025 A grant with lock=1 SHALL move the FSM to OWNn for the granted port n.
REQ-026 In OWNn, only port n SHALL be granted, whatever the other port requests.
REQ-027 In OWNn, a grant to port n with lock=0 SHALL return the FSM to OPEN; OWNn SHALL persist while port n idles.
REQ-028 A write followed by a read to the same address on the next cycle SHALL return the written data; ordering follows grant order.

Reset
REQ-029 While sclr=1, both gnt, both rvalid, mem_rden and mem_wren SHALL be 0.
REQ-030 While sclr=1, mem_address, mem_byteena and mem_data SHALL be 0, and p0_rdata/p1_rdata SHALL follow mem_q.
REQ-031 On sclr=1, the FSM SHALL go to OPEN and the last-grant pointer SHALL be set to 1.
REQ-032 For a read granted in the cycle before sclr rises, the pending rvalid SHALL be suppressed.
REQ-033 The first grant SHALL be possible in the first cycle after sclr falls.

Configuration
REQ-034 With macro BRAM_ARB_FIXED_PRIO_EN defined, port 0 SHALL always win ties in OPEN and the last-grant pointer SHALL be omitted.
REQ-035 Without BRAM_ARB_FIXED_PRIO_EN, round-robin per REQ-024 SHALL apply.
REQ-036 Locking SHALL behave identically in both builds.

Verification
REQ-037 Scenario: p0 writes 0xA0000003 to addr 3 with be=4'b1111, then reads addr 3 -> p0_rvalid one cycle after the read grant, p0_rdata=0xA0000003.
REQ-038 Scenario: p0 and p1 request together continuously for 4 cycles -> grants alternate p0,p1,p0,p1 (round-robin) or p0 all 4 cycles (fixed-priority build).
REQ-039 Scenario: p1 writes 0xDEADBEEF to addr 0x000A with be=4'b0011 over prior 0x00000000, then reads it -> p1_rdata=0x0000BEEF.
REQ-040 Scenario: p0 is granted with lock=1, then p1 requests for 3 cycles while p0 issues two more accesses with lock=1,1 then lock=0 -> p1_gnt=0 until the cycle after p0's lock=0 grant.
REQ-041 Scenario: p0 read of addr 0x000B is granted and sclr=1 is asserted the next cycle -> p0_rvalid stays 0, FSM in OPEN, and the next tie goes to port 0.
REQ-042 Scenario: both ports request in every cycle, across all scenarios -> p0_gnt and p1_gnt are never 1 together, and mem_rden and mem_wren are never 1 together.
